// File: rtl/rgb_led_arbiter.sv
// Round-robin owner of the board RGB LED with a minimum hold time.
// The owner's {r,g,b} duties drive an active-low PWM on LED_R/LED_G/LED_B.
module rgb_led_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int PWM_BITS    = 8,
  parameter int HOLD_CYCLES = 12000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*3*PWM_BITS-1:0]   color,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            busy,
  output logic                            LED_R,
  output logic                            LED_G,
  output logic                            LED_B
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [HC_W-1:0]     hold_q, hold_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] duty_r_q, duty_r_d;
  logic [PWM_BITS-1:0] duty_g_q, duty_g_d;
  logic [PWM_BITS-1:0] duty_b_q, duty_b_d;
  logic                led_r_q, led_r_d;
  logic                led_g_q, led_g_d;
  logic                led_b_q, led_b_d;

  logic [3*PWM_BITS-1:0] slice [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign slice[gi] = color[gi*3*PWM_BITS +: 3*PWM_BITS];
    end
  endgenerate

  // Search runs from the largest offset down so the nearest index after
  // last wins; offset NUM_REQ lands back on last itself.
  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(last_q) + off) % NUM_REQ);
      if (req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  logic arb_evt;

  assign arb_evt = ((state_q == IDLE) && (|req)) ||
                   ((state_q == HOLD) && ((hold_q == '0) || !req[last_q]));

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    hold_d   = hold_q;
    pwm_d    = pwm_q + 1'b1;
    duty_r_d = duty_r_q;
    duty_g_d = duty_g_q;
    duty_b_d = duty_b_q;

    if (arb_evt) begin
      if (found) begin
        state_d  = HOLD;
        grant_d  = NUM_REQ'(1) << win;
        last_d   = win;
        hold_d   = HC_W'(HOLD_CYCLES - 1);
        pwm_d    = '0;
        {duty_r_d, duty_g_d, duty_b_d} = slice[win];
      end else begin
        state_d = IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    end else if (state_q == HOLD) begin
      if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end
      // Colour edits only land on a PWM period boundary.
      if (&pwm_q) begin
        {duty_r_d, duty_g_d, duty_b_d} = slice[last_q];
      end
    end

    led_r_d = ~((state_q == HOLD) && (pwm_q < duty_r_q));
    led_g_d = ~((state_q == HOLD) && (pwm_q < duty_g_q));
    led_b_d = ~((state_q == HOLD) && (pwm_q < duty_b_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= IDX_W'(NUM_REQ - 1);
      grant_q  <= '0;
      hold_q   <= '0;
      pwm_q    <= '0;
      duty_r_q <= '0;
      duty_g_q <= '0;
      duty_b_q <= '0;
      led_r_q  <= 1'b1;
      led_g_q  <= 1'b1;
      led_b_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      hold_q   <= hold_d;
      pwm_q    <= pwm_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
      led_r_q  <= led_r_d;
      led_g_q  <= led_g_d;
      led_b_q  <= led_b_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == HOLD);
  assign LED_R = led_r_q;
  assign LED_G = led_g_q;
  assign LED_B = led_b_q;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Bench for rgb_led_arbiter: per-cycle comparison against a behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_rgb_led_arbiter;

  localparam int N  = 3;
  localparam int PB = 8;
  localparam int HC = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*3*PB-1:0] color;
  logic [N-1:0]      grant;
  logic              busy;
  logic              led_r, led_g, led_b;

  always #5 clk = ~clk;

  rgb_led_arbiter #(
    .NUM_REQ(N), .PWM_BITS(PB), .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .color(color),
    .grant(grant), .busy(busy),
    .LED_R(led_r), .LED_G(led_g), .LED_B(led_b)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner (-1 = nobody), age = cycles since the grant was issued,
  // phase = PWM position, duty[0..2] = r,g,b of the displayed colour.
  int   m_owner, m_last, m_age, m_phase;
  int   m_duty [3];
  logic m_lr, m_lg, m_lb;

  function automatic int col_of(input int i, input int c);
    logic [23:0] s;
    s = color[i*24 +: 24];
    return int'(s[(2-c)*8 +: 8]);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_age   = 0;
    m_phase = 0;
    for (int c = 0; c < 3; c++) m_duty[c] = 0;
    m_lr = 1'b1; m_lg = 1'b1; m_lb = 1'b1;
  endtask

  task automatic model_step();
    bit ev;
    int nxt;
    int idx;
    m_lr = !(m_owner >= 0 && m_phase < m_duty[0]);
    m_lg = !(m_owner >= 0 && m_phase < m_duty[1]);
    m_lb = !(m_owner >= 0 && m_phase < m_duty[2]);
    ev = (m_owner < 0 && req != 0) ||
         (m_owner >= 0 && (m_age >= HC - 1 || !req[m_owner]));
    if (ev) begin
      nxt = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (nxt < 0 && req[idx]) nxt = idx;
      end
      if (nxt >= 0) begin
        m_owner = nxt;
        m_last  = nxt;
        m_age   = 0;
        m_phase = 0;
        for (int c = 0; c < 3; c++) m_duty[c] = col_of(nxt, c);
      end else begin
        m_owner = -1;
        m_phase = (m_phase + 1) % 256;
      end
    end else begin
      if (m_owner >= 0) begin
        if (m_phase == 255)
          for (int c = 0; c < 3; c++) m_duty[c] = col_of(m_owner, c);
        m_age++;
      end
      m_phase = (m_phase + 1) % 256;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
      check("busy",  int'(busy),  (m_owner >= 0) ? 1 : 0);
      check("leds",  int'({led_r, led_g, led_b}), int'({m_lr, m_lg, m_lb}));
    end
  end

  task automatic set_col(input int i, input int r, input int g, input int b);
    color[i*24 +: 24] = {8'(r), 8'(g), 8'(b)};
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  int lo_r, lo_g, lo_b, lo1, lo2, bad, zeros, nr, len;
  int rv [8];
  int rl [8];
  logic [N-1:0] cur;

  initial begin
    rst = 1'b1; req = '0; color = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_grant", int'(grant), 0);
    check("reset_busy",  int'(busy), 0);
    check("reset_leds",  int'({led_r, led_g, led_b}), 7);

    // Asynchronous reset in the middle of a hold
    set_col(0, 255, 255, 255);
    req = 3'b001;
    repeat (50) @(posedge clk);
    #2 check("pre_rst_leds", int'({led_r, led_g, led_b}), 0);
    #1 rst = 1'b1;
    #1;
    check("async_grant", int'(grant), 0);
    check("async_busy",  int'(busy), 0);
    check("async_leds",  int'({led_r, led_g, led_b}), 7);
    req = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Single requester duty counts
    do_reset();
    set_col(0, 255, 0, 128);
    req = 3'b001;
    @(posedge clk); @(negedge clk);
    check("single_grant", int'(grant), 1);
    lo_r = 0; lo_g = 0; lo_b = 0;
    repeat (256) begin
      @(negedge clk);
      if (!led_r) lo_r++;
      if (!led_g) lo_g++;
      if (!led_b) lo_b++;
    end
    check("single_low_r", lo_r, 255);
    check("single_low_g", lo_g, 0);
    check("single_low_b", lo_b, 128);

    // Rotation with all three requesting
    do_reset();
    set_col(1, 10, 20, 30);
    set_col(2, 90, 0, 250);
    req = 3'b111;
    @(posedge clk); @(negedge clk);
    cur = grant; len = 1; nr = 0; zeros = (grant == 0) ? 1 : 0;
    for (int s = 1; s < 3100; s++) begin
      @(negedge clk);
      if (grant == 0) zeros++;
      if (grant == cur) len++;
      else begin
        if (nr < 8) begin rv[nr] = int'(cur); rl[nr] = len; end
        nr++;
        cur = grant; len = 1;
      end
    end
    check("rot_runs", nr, 3);
    check("rot_g0", rv[0], 1);
    check("rot_g1", rv[1], 2);
    check("rot_g2", rv[2], 4);
    check("rot_g3", int'(cur), 1);
    check("rot_len0", rl[0], HC);
    check("rot_len1", rl[1], HC);
    check("rot_len2", rl[2], HC);
    check("rot_zeros", zeros, 0);

    // Early release by owner 1
    do_reset();
    req = 3'b110;
    @(posedge clk); @(negedge clk);
    check("early_first", int'(grant), 2);
    repeat (299) @(posedge clk);
    #2 req = 3'b100;
    @(posedge clk); @(negedge clk);
    check("early_next", int'(grant), 4);
    repeat (20) @(posedge clk);

    // Sole persistent requester
    do_reset();
    set_col(1, 200, 30, 100);
    req = 3'b010;
    @(posedge clk);
    bad = 0;
    repeat (3500) begin
      @(negedge clk);
      if (grant != 3'b010 || !busy) bad++;
    end
    check("sole_bad", bad, 0);

    // Colour update lands at the period boundary
    do_reset();
    set_col(0, 0, 0, 0);
    req = 3'b001;
    @(posedge clk);
    lo1 = 0; lo2 = 0;
    for (int k = 1; k <= 512; k++) begin
      @(posedge clk);
      if (k == 100) begin #2 set_col(0, 0, 64, 0); end
      @(negedge clk);
      if (!led_g) begin
        if (k <= 256) lo1++;
        else          lo2++;
      end
    end
    check("col_period1_g", lo1, 0);
    check("col_period2_g", lo2, 64);

    // Randomised traffic against the model
    do_reset();
    for (int it = 0; it < 40; it++) begin
      @(posedge clk); #2;
      req = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++)
        set_col(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      repeat ($urandom_range(1, 350)) @(posedge clk);
      #2 set_col($urandom_range(0, N - 1), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255));
      repeat ($urandom_range(1, 350)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Shares the board's single RGB LED among `NUM_REQ` requesters (status, heartbeat, error sources) using a round-robin arbiter with a minimum hold time. The granted requester's per-channel 8-bit duty values drive a PWM engine that generates the active-low `LED_R`/`LED_G`/`LED_B` pins. This block replaces direct counter-to-LED wiring at the top level, so any number of sources can display colours without contention.

## Interface

Parameters:
- `NUM_REQ`, 3: number of requesters, ≥ 2.
- `PWM_BITS`, 8: duty and PWM counter width.
- `HOLD_CYCLES`, 12000000: cycles a grant is held while its requester keeps requesting, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  `NUM_REQ`  request level per requester.
- `color`  in  `NUM_REQ*3*PWM_BITS`  per requester i: `{r,g,b}` duty at bits `[i*3*PWM_BITS +: 3*PWM_BITS]`, with r in the MSBs.
- `grant`  out  `NUM_REQ`  one-hot current owner; all zero when idle.
- `busy`  out  1  high while any grant is active.
- `LED_R`, `LED_G`, `LED_B`  out  1 each  active-low LED drive.

## Operation

- States:
  - IDLE: `grant`=0 and LEDs off.
  - HOLD: one requester owns the LED.
- Arbitration event: a cycle in which a new owner is chosen. It occurs when:
  - the block is in IDLE and `req`≠0, or
  - the block is in HOLD and the hold counter is 0, or
  - the block is in HOLD and `req[owner]`=0.
- Round-robin search starts at index `last+1` mod `NUM_REQ` and wraps, including `last` itself. `last` is the most recently granted index; it resets to `NUM_REQ-1`, so index 0 wins first.
- Event outcome:
  - If the search finds a requester: enter or stay in HOLD, register the new one-hot `grant`, set `last`, and load the hold counter with `HOLD_CYCLES-1`.
  - If no request is found: go to IDLE.
- A sole persistent requester is re-granted back-to-back, with no IDLE gap and `busy` staying 1.
- In HOLD the hold counter decrements by 1 per cycle and saturates at 0.
- PWM:
  - `pwm_cnt` (`PWM_BITS` wide) increments every cycle and wraps. It is forced to 0 on every grant load, including re-grants.
  - Each of the three duty registers is loaded from the new owner's `color` slice on a grant load. While holding, they reload whenever `pwm_cnt` is all-ones, so colour changes take effect only at period boundaries.
  - A channel is on when `pwm_cnt < duty`. Duty 0 means always off; duty `2^PWM_BITS-1` means on for 255 of 256 cycles.
  - LED pins are registered: `LED_x <= ~(HOLD && pwm_cnt < duty_x)`.
- `color` inputs of non-owners are ignored. Multiple simultaneous requests are resolved only by round-robin order.

## Timing

- Reset values, applied immediately on `rst` assertion without waiting for a clock edge:
  - `grant`=0, `busy`=0, `LED_R`=`LED_G`=`LED_B`=1.
  - state IDLE, `last`=`NUM_REQ-1`.
  - hold counter=0, `pwm_cnt`=0, duties=0.
- `req` sampled high in IDLE at edge N gives `grant` and `busy` valid after edge N+1, with `pwm_cnt`=0. The first LED level appears after edge N+2.
- A held grant lasts exactly `HOLD_CYCLES` cycles, then the new `grant` appears on the next cycle with no zero cycle between owners.
- Early release: `req[owner]` seen low at edge N gives the new `grant` (or 0) after edge N+1. The LEDs reflect the change one cycle later.
- `rst` asserted mid-HOLD aborts the grant. After deassertion, the first grant goes to the lowest requesting index.
- `req` changes on non-owners during HOLD have no effect until the next arbitration event.

## Test plan

- Reset: assert `rst` mid-HOLD between clock edges; `grant`=000, `busy`=0 and LEDs=111 change immediately, asynchronously.
- Single requester: `req`=001, color0 r=255 g=0 b=128, `HOLD_CYCLES`=1000; over 256 cycles `LED_R` is low 255, `LED_G` low 0, `LED_B` low 128. `grant`=001 one cycle after `req`.
- Rotation: `req`=111 held, `HOLD_CYCLES`=1000; `grant` sequence is 001, 010, 100, 001, each exactly 1000 cycles, with no 000 cycle.
- Early release: owner 1 drops `req` 300 cycles into its hold with `req[2]`=1; `grant`=100 appears one cycle later and `pwm_cnt` restarts at 0.
- Sole persistent requester: `req`=010 for 3500 cycles with `HOLD_CYCLES`=1000; `grant` stays 010 and `busy` stays 1 throughout. `pwm_cnt` resets at each 1000-cycle re-grant.
- Colour update: change color0 g from 0 to 64 mid-period; the new duty appears only after `pwm_cnt` wraps, and the next period shows 64 low cycles on `LED_G`.
